// File: rtl/mdu_if.sv
// Start/busy/done handshake and HI/LO result bus between the MIPS controller and the MDU.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  mdu_op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output A, B, mdu_op, start, input busy, done, hi, lo);
    modport slave  (input A, B, mdu_op, start, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit holding HI/LO: 32-cycle shift-add multiply, restoring divide.
// Divide datapath is compiled only when MDU_DIV_EN is defined.
module mdu #(
    parameter logic [31:0] HILO_RST = 32'h00000000
) (
    input logic  clk,
    input logic  rst_n,
    mdu_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        fix_done;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [63:0] acc;
    logic [31:0] opb;
    logic        neg_q;

    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic               accept;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [32:0]        mul_sum;
    logic [63:0]        mul_next;
    logic [63:0]        mul_fix;
    logic [63:0]        calc_next;
    logic [63:0]        fix_val;

`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;

    logic        is_div;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] opa;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] div_fix;

    // acc holds {remainder, dividend/quotient}; a borrow out of the trial subtract restores.
    always_comb begin
        div_diff         = acc[63:31] - {1'b0, opb};
        div_next         = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
        div_fix[63:32]   = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        div_fix[31:0]    = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        if (div_zero) begin
            div_fix = {opa, 32'hFFFFFFFF};
        end
    end
`endif

    always_comb begin
        a_s    = bus.A;
        b_s    = bus.B;
        op_mul = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
`ifdef MDU_DIV_EN
        op_div    = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);
        op_signed = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_DIV);
`else
        op_div    = 1'b0;
        op_signed = (bus.mdu_op == OP_MULT);
`endif
        a_neg  = op_signed && (a_s < 0);
        b_neg  = op_signed && (b_s < 0);
        a_mag  = a_neg ? 32'(-a_s) : bus.A;
        b_mag  = b_neg ? 32'(-b_s) : bus.B;
        accept = (state == S_IDLE) && bus.start && (op_mul || op_div);
    end

    // Multiplier sits in acc[31:0] and shifts out as the product shifts in from the top.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        mul_fix  = neg_q ? (~acc + 64'd1) : acc;
`ifdef MDU_DIV_EN
        calc_next = is_div ? div_next : mul_next;
        fix_val   = is_div ? div_fix : mul_fix;
`else
        calc_next = mul_next;
        fix_val   = mul_fix;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            acc   <= {32'd0, a_mag};
            opb   <= b_mag;
            neg_q <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            is_div   <= op_div;
            neg_r    <= a_neg;
            div_zero <= (bus.B == 32'd0);
            opa      <= bus.A;
`endif
        end else if (state == S_CALC) begin
            acc <= calc_next;
        end else if ((state == S_FIX) && !fix_done) begin
            acc <= fix_val;
        end
    end

    // FIX spends one cycle on sign correction and a second committing HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 5'd0;
            fix_done <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= HILO_RST;
            lo_r     <= HILO_RST;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (op_mul || op_div) begin
                            state  <= S_CALC;
                            cnt    <= 5'd0;
                            busy_r <= 1'b1;
                        end else if (bus.mdu_op == OP_MTHI) begin
                            hi_r   <= bus.A;
                            done_r <= 1'b1;
                        end else if (bus.mdu_op == OP_MTLO) begin
                            lo_r   <= bus.A;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state    <= S_FIX;
                        fix_done <= 1'b0;
                    end
                end
                S_FIX: begin
                    if (!fix_done) begin
                        fix_done <= 1'b1;
                    end else begin
                        hi_r     <= acc[63:32];
                        lo_r     <= acc[31:0];
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        fix_done <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for the multiply/divide unit; divide checks follow MDU_DIV_EN.
module tb_mdu;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_if bus();

    mdu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Drive a request at the falling edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A      = a;
        bus.B      = b;
        bus.mdu_op = op;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.A      = 32'hDEADBEEF;
        bus.B      = 32'h0BADF00D;
        bus.mdu_op = 3'b110;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        bus.start  = 1'b0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.mdu_op = OP_MULT;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++;
        if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
        checks++;
        if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
    endtask

    task automatic test_mult();
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mult_e0: busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                errors++;
                $display("FAIL mult_calc E%0d: busy=%b done=%b hi=%h lo=%h want 1 0 %h %h",
                         k, bus.busy, bus.done, bus.hi, bus.lo, exp_hi, exp_lo);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mult_e34: done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFF1) begin
            errors++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff fffffff1", bus.hi, bus.lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", bus.done); end
        exp_hi = 32'hFFFFFFFF;
        exp_lo = 32'hFFFFFFF1;
    endtask

    task automatic test_multu();
        int n;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        checks++;
        if (n != 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", n); end
        checks++;
        if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001", bus.hi, bus.lo);
        end
        exp_hi = 32'hFFFFFFFE;
        exp_lo = 32'h00000001;
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        logic [2:0]  ops[4];
        logic [31:0] as[4];
        logic [31:0] bs[4];
        logic [31:0] his[4];
        logic [31:0] los[4];
        int n;
        ops = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        as  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9};
        bs  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
        his = '{32'hFFFFFFFF, 32'd7, 32'h0, 32'hFFFFFFF9};
        los = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n);
            checks++;
            if (n != 34) begin errors++; $display("FAIL div%0d_latency: got %0d want 34", i, n); end
            checks++;
            if (bus.hi !== his[i] || bus.lo !== los[i]) begin
                errors++;
                $display("FAIL div%0d_result: hi=%h lo=%h want %h %h", i, bus.hi, bus.lo, his[i], los[i]);
            end
        end
        exp_hi = 32'hFFFFFFF9;
        exp_lo = 32'hFFFFFFFF;
    endtask
`else
    task automatic test_div();
        int seen;
        for (int i = 0; i < 2; i++) begin
            issue((i == 0) ? OP_DIV : OP_DIVU, 32'h80000000, 32'hFFFFFFFF);
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (seen != 0) begin errors++; $display("FAIL div_disabled%0d: active cycles %0d want 0", i, seen); end
            checks++;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                errors++; $display("FAIL div_disabled%0d_hilo: hi=%h lo=%h want %h %h", i, bus.hi, bus.lo, exp_hi, exp_lo);
            end
        end
    endtask
`endif

    task automatic test_reserved();
        int seen;
        for (int i = 0; i < 2; i++) begin
            issue((i == 0) ? 3'b110 : 3'b111, 32'h55555555, 32'h3);
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (seen != 0) begin errors++; $display("FAIL reserved%0d: active cycles %0d want 0", i, seen); end
            checks++;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                errors++; $display("FAIL reserved%0d_hilo: hi=%h lo=%h want %h %h", i, bus.hi, bus.lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        issue(OP_MTHI, 32'h12345678, 32'h0);
        checks++;
        if (bus.hi !== 32'h12345678 || bus.lo !== exp_lo) begin
            errors++; $display("FAIL mthi_value: hi=%h lo=%h want 12345678 %h", bus.hi, bus.lo, exp_lo);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mthi_handshake: done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done_pulse: got %b want 0", bus.done); end
        issue(OP_MTLO, 32'h9ABCDEF0, 32'h0);
        checks++;
        if (bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h done=%b busy=%b want 12345678 9abcdef0 1 0",
                     bus.hi, bus.lo, bus.done, bus.busy);
        end
        exp_hi = 32'h12345678;
        exp_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_busy_ignore();
        int n;
        int seen;
        issue(OP_MULT, 32'd7, 32'd6);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.A      = 32'd2;
        bus.B      = 32'd3;
        bus.mdu_op = OP_MULTU;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", bus.busy); end
        wait_done(n);
        checks++;
        if (n != 24) begin errors++; $display("FAIL ignore_latency: got %0d want 24", n); end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
            errors++; $display("FAIL ignore_result: hi=%h lo=%h want 00000000 0000002a", bus.hi, bus.lo);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL ignore_no_second: active cycles %0d want 0", seen); end
        exp_hi = 32'h0;
        exp_lo = 32'd42;
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(OP_MULT, 32'd1000, 32'd1000);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++; $display("FAIL rstmid_hilo: hi=%h lo=%h want 0 0", bus.hi, bus.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: active cycles %0d want 0", seen); end
        exp_hi = 32'h0;
        exp_lo = 32'h0;
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done(n);
        checks++;
        if (n != 34 || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            errors++; $display("FAIL b2b_first: n=%0d hi=%h lo=%h want 34 0 c", n, bus.hi, bus.lo);
        end
        issue(OP_MULTU, 32'd5, 32'd6);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b want 1", bus.busy); end
        wait_done(n);
        checks++;
        if (n != 34 || bus.hi !== 32'h0 || bus.lo !== 32'd30) begin
            errors++; $display("FAIL b2b_second: n=%0d hi=%h lo=%h want 34 0 1e", n, bus.hi, bus.lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_reserved();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
